serial20_rx: RTL and testbench

SERIAL20_RX -- requirements
Module: serial20_rx

---
 rtl/serial20_rx.sv | 120 ++++++++++++
 tb/tb_serial20_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial20_rx.sv
// rtl/serial20_rx.sv - serial frame receiver splitting coordinate/MAD fields with a running minimum-MAD tracker
module serial20_rx #(
    parameter int COORD_W = 8,
    parameter int MAD_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_in_port,
    input  logic               frame_start,
    input  logic               best_clr,
    output logic [COORD_W-1:0] coordinate,
    output logic [MAD_W-1:0]   mad,
    output logic               word_valid,
    output logic               frame_err,
    output logic               busy,
    output logic [COORD_W-1:0] best_coordinate,
    output logic [MAD_W-1:0]   best_mad,
    output logic               best_valid
);

    localparam int FRAME_W = COORD_W + MAD_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shreg_nxt;
    logic               done;
    logic               abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // A frame_start always wins: it opens a fresh frame whose MSB is the current bit.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        done        = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    shreg_nxt   = {{(FRAME_W-1){1'b0}}, s_in_port};
                    bit_cnt_nxt = CNT_W'(1);
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    abort       = 1'b1;
                    shreg_nxt   = {{(FRAME_W-1){1'b0}}, s_in_port};
                    bit_cnt_nxt = CNT_W'(1);
                end else if (bit_cnt == LAST_BIT) begin
                    done        = 1'b1;
                    shreg_nxt   = {shreg[FRAME_W-2:0], s_in_port};
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    shreg_nxt   = {shreg[FRAME_W-2:0], s_in_port};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            coordinate <= '0;
            mad        <= '0;
        end else begin
            word_valid <= done;
            frame_err  <= abort;
            if (done) begin
                coordinate <= shreg_nxt[FRAME_W-1:MAD_W];
                mad        <= shreg_nxt[MAD_W-1:0];
            end
        end
    end

    // A coincident clear still lets the current word in, so it becomes the new best.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_coordinate <= '0;
            best_mad        <= '1;
            best_valid      <= 1'b0;
        end else if (word_valid && (best_clr || !best_valid || (mad < best_mad))) begin
            best_coordinate <= coordinate;
            best_mad        <= mad;
            best_valid      <= 1'b1;
        end else if (best_clr) begin
            best_coordinate <= '0;
            best_mad        <= '1;
            best_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial20_rx.sv
// tb/tb_serial20_rx.sv - self-checking bench for serial20_rx against a history-based reference model
module tb_serial20_rx;

    localparam int FRAME_W = 20;
    localparam int HN      = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_in_port = 1'b0;
    logic        frame_start = 1'b0;
    logic        best_clr = 1'b0;
    logic [7:0]  coordinate;
    logic [11:0] mad;
    logic        word_valid;
    logic        frame_err;
    logic        busy;
    logic [7:0]  best_coordinate;
    logic [11:0] best_mad;
    logic        best_valid;

    serial20_rx #(.COORD_W(8), .MAD_W(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_in_port       (s_in_port),
        .frame_start     (frame_start),
        .best_clr        (best_clr),
        .coordinate      (coordinate),
        .mad             (mad),
        .word_valid      (word_valid),
        .frame_err       (frame_err),
        .busy            (busy),
        .best_coordinate (best_coordinate),
        .best_mad        (best_mad),
        .best_valid      (best_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit fs_h [HN];
    bit bit_h[HN];
    bit clr_h[HN];
    int base = 0;
    bit pending_release = 1'b0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit fs_at(input int i);
        if (i < base || i < 0 || i >= HN) return 1'b0;
        return fs_h[i];
    endfunction

    // Receiver is mid-frame in cycle t when some frame began within the previous 19 cycles.
    function automatic bit in_shift(input int t);
        for (int p = t - 1; p >= t - (FRAME_W - 1); p--)
            if (fs_at(p)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit wv_exp(input int t);
        int s;
        s = t - FRAME_W;
        if (!fs_at(s)) return 1'b0;
        for (int k = s + 1; k < t; k++)
            if (fs_at(k)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [19:0] word_at(input int s);
        logic [19:0] w;
        for (int k = 0; k < FRAME_W; k++) w[FRAME_W-1-k] = bit_h[s+k];
        return w;
    endfunction

    logic [7:0]  m_coord, m_bcoord;
    logic [11:0] m_mad, m_bmad;
    bit          m_bv, m_prev_wv;

    initial begin : compare
        int t;
        bit w, e, b;
        logic [19:0] wd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_coord = '0; m_mad = '0; m_bcoord = '0; m_bmad = '1;
                m_bv = 1'b0; m_prev_wv = 1'b0;
            end else begin
                t = cyc;
                if (t - 1 >= base) begin
                    if (clr_h[t-1]) begin
                        m_bv = 1'b0; m_bmad = '1; m_bcoord = '0;
                    end
                    if (m_prev_wv && (!m_bv || m_mad < m_bmad)) begin
                        m_bv = 1'b1; m_bmad = m_mad; m_bcoord = m_coord;
                    end
                end
                w = wv_exp(t);
                if (w) begin
                    wd = word_at(t - FRAME_W);
                    m_coord = wd[19:12];
                    m_mad   = wd[11:0];
                end
                m_prev_wv = w;
                e = fs_at(t - 1) && in_shift(t - 1);
                b = in_shift(t);
                check("word_valid", 32'(word_valid), 32'(w));
                check("frame_err", 32'(frame_err), 32'(e));
                check("busy", 32'(busy), 32'(b));
                check("coordinate", 32'(coordinate), 32'(m_coord));
                check("mad", 32'(mad), 32'(m_mad));
                check("best_valid", 32'(best_valid), 32'(m_bv));
                check("best_mad", 32'(best_mad), 32'(m_bmad));
                check("best_coordinate", 32'(best_coordinate), 32'(m_bcoord));
            end
        end
    end

    task automatic step(input bit fs, input bit b, input bit clr);
        @(posedge clk);
        #1;
        if (pending_release) begin
            rst_n = 1'b1;
            base = cyc;
            pending_release = 1'b0;
        end
        frame_start = fs;
        s_in_port   = b;
        best_clr    = clr;
        fs_h[cyc]  = fs;
        bit_h[cyc] = b;
        clr_h[cyc] = clr;
    endtask

    task automatic send(input logic [19:0] v, input int first, input int n, input bit fs_first);
        for (int k = first; k < first + n; k++)
            step(fs_first && (k == first), v[FRAME_W-1-k], 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_coordinate"}, 32'(coordinate), 32'h0);
        check({tag, "_mad"}, 32'(mad), 32'h0);
        check({tag, "_best_valid"}, 32'(best_valid), 32'h0);
        check({tag, "_best_mad"}, 32'(best_mad), 32'hFFF);
        check({tag, "_best_coordinate"}, 32'(best_coordinate), 32'h0);
    endtask

    initial begin : main
        int since;
        bit fs;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_reset_outputs("reset");

        // Single frame, started on the very first edge after reset release
        pending_release = 1'b1;
        send(20'hA53C7, 0, 20, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_wv", 32'(word_valid), 32'h1);
        check("single_coord", 32'(coordinate), 32'hA5);
        check("single_mad", 32'(mad), 32'h3C7);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_best_mad", 32'(best_mad), 32'h3C7);
        check("single_best_coord", 32'(best_coordinate), 32'hA5);
        check("single_best_valid", 32'(best_valid), 32'h1);

        // Back-to-back frames
        send(20'h12345, 0, 20, 1'b1);
        send(20'h0F010, 0, 20, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_best_coord", 32'(best_coordinate), 32'h0F);
        check("b2b_best_mad", 32'(best_mad), 32'h010);

        // Abort in cycle 7 of a frame, restart with the current bit
        send(20'h9E3D1, 0, 7, 1'b1);
        send(20'hC3A5F, 0, 1, 1'b1);
        send(20'hC3A5F, 1, 1, 1'b0);
        @(negedge clk);
        check("abort_frame_err", 32'(frame_err), 32'h1);
        send(20'hC3A5F, 2, 18, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_wv", 32'(word_valid), 32'h1);
        check("abort_coord", 32'(coordinate), 32'hC3);
        check("abort_mad", 32'(mad), 32'hA5F);

        // Ties keep the earlier entry; clear coincident with a word loads it
        step(1'b0, 1'b0, 1'b1);
        send(20'h01050, 0, 20, 1'b1);
        send(20'h02050, 0, 20, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("tie_best_coord", 32'(best_coordinate), 32'h01);
        check("tie_best_mad", 32'(best_mad), 32'h050);
        send(20'h337FF, 0, 20, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("clrwv_best_mad", 32'(best_mad), 32'h7FF);
        check("clrwv_best_valid", 32'(best_valid), 32'h1);
        check("clrwv_best_coord", 32'(best_coordinate), 32'h33);

        // Reset mid-frame
        send(20'h5A5A5, 0, 10, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        frame_start = 1'b0;
        best_clr = 1'b0;
        fs_h[cyc] = 1'b0;
        clr_h[cyc] = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        pending_release = 1'b1;
        send(20'h96E1B, 0, 20, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("postrst_wv", 32'(word_valid), 32'h1);
        check("postrst_coord", 32'(coordinate), 32'h96);
        check("postrst_mad", 32'(mad), 32'hE1B);

        // Idle noise
        repeat (50) step(1'b0, 1'($urandom_range(1)), 1'b0);
        @(negedge clk);
        check("noise_busy", 32'(busy), 32'h0);

        // Randomized traffic: aborts, back-to-back starts, clears
        since = 100;
        for (int i = 0; i < 1500; i++) begin
            if (since == FRAME_W) fs = 1'($urandom_range(1));
            else fs = ($urandom_range(15) == 0);
            step(fs, 1'($urandom_range(1)), ($urandom_range(39) == 0));
            since = fs ? 1 : since + 1;
        end
        repeat (25) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
